pingpong_buf: RTL and testbench

//  Parametrised N-bank successor of the single-bank source/destination buffers.

---
 rtl/pingpong_buf_pkg.sv | 8 +
 rtl/pingpong_buf_if.sv | 30 +++
 rtl/pingpong_buf_bank_ram.sv | 23 ++
 rtl/pingpong_buf.sv | 52 +++++
 tb/tb_pingpong_buf.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/pingpong_buf_pkg.sv
// tdnn_buf_pkg: data/address defaults and types shared by the buffer and the MAC array
package tdnn_buf_pkg;
  localparam int DW_DEF = 32;
  localparam int AW_DEF = 12;
  localparam int NBANK_DEF = 2;
  typedef logic [DW_DEF-1:0] data_t;
  typedef logic [AW_DEF-1:0] addr_t;
endpackage

// File: rtl/pingpong_buf_if.sv
// pingpong_buf_if: host fill port and compute read port of the ping-pong buffer
interface pingpong_buf_if import tdnn_buf_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int NBANK = NBANK_DEF
) ();
  localparam int CW = $clog2(NBANK) + 1;
  logic          src_v;
  logic [AW-1:0] src_a;
  logic [DW-1:0] src_d;
  logic          src_last;
  logic          src_rdy;
  logic          exec;
  logic [AW-1:0] ia;
  logic [DW-1:0] d;
  logic          d_v;
  logic          rd_done;
  logic          rd_rdy;
  logic [CW-1:0] full_cnt;
  logic          err_ovf;
  logic          err_udf;
  modport master (
    output src_v, src_a, src_d, src_last, exec, ia, rd_done,
    input  src_rdy, d, d_v, rd_rdy, full_cnt, err_ovf, err_udf
  );
  modport slave (
    input  src_v, src_a, src_d, src_last, exec, ia, rd_done,
    output src_rdy, d, d_v, rd_rdy, full_cnt, err_ovf, err_udf
  );
endinterface

// File: rtl/pingpong_buf_bank_ram.sv
// bank_ram: all banks in one array, one write port and one registered read port
module bank_ram #(
  parameter int DW = 32,
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] rd
);
  logic [DW-1:0] mem [2**AW];
  // storage is never reset
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  // read register holds its value between accepted reads
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rd <= '0;
    else if (re) rd <= mem[ra];
endmodule

// File: rtl/pingpong_buf.sv
// pingpong_buf: N-bank ring buffer, host fills one bank while compute reads a committed one
module pingpong_buf import tdnn_buf_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int NBANK = NBANK_DEF
) (
  input logic clk,
  input logic rst_n,
  pingpong_buf_if.slave bus
);
  localparam int PW = $clog2(NBANK);
  localparam int CW = PW + 1;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic src_rdy, rd_rdy, wr_acc, commit, rd_acc, rel;
  assign src_rdy = cnt < CW'(NBANK);
  assign rd_rdy  = cnt != '0;
  assign wr_acc  = bus.src_v & src_rdy;
  assign commit  = wr_acc & bus.src_last;
  assign rd_acc  = bus.exec & rd_rdy;
  assign rel     = bus.rd_done & rd_rdy;
  assign bus.src_rdy  = src_rdy;
  assign bus.rd_rdy   = rd_rdy;
  assign bus.full_cnt = cnt;
  // ring pointers, committed-bank count, read-valid and sticky error flags
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      bus.d_v     <= 1'b0;
      bus.err_ovf <= 1'b0;
      bus.err_udf <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr + PW'(commit);
      rd_ptr      <= rd_ptr + PW'(rel);
      cnt         <= cnt + CW'(commit) - CW'(rel);
      bus.d_v     <= rd_acc;
      bus.err_ovf <= bus.err_ovf | (bus.src_v & ~src_rdy);
      bus.err_udf <= bus.err_udf | ((bus.exec | bus.rd_done) & ~rd_rdy);
    end
  bank_ram #(.DW(DW), .AW(PW + AW)) u_ram (
    .clk (clk),
    .rst_n (rst_n),
    .we  (wr_acc),
    .wa  ({wr_ptr, bus.src_a}),
    .wd  (bus.src_d),
    .re  (rd_acc),
    .ra  ({rd_ptr, bus.ia}),
    .rd  (bus.d)
  );
endmodule

// File: tb/tb_pingpong_buf.sv
// tb_pingpong_buf: directed scenario checks of the two-bank ping-pong buffer
module tb_pingpong_buf;
  import tdnn_buf_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int passed = 0;
  pingpong_buf_if #(.DW(32), .AW(12), .NBANK(2)) bus ();
  pingpong_buf #(.DW(32), .AW(12), .NBANK(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int v, input logic last);
    bus.src_v = 1'b1;
    bus.src_a = addr_t'(a);
    bus.src_d = data_t'(v);
    bus.src_last = last;
    step();
    bus.src_v = 1'b0;
    bus.src_last = 1'b0;
  endtask

  task automatic rd(input int a, input logic done);
    bus.exec = 1'b1;
    bus.ia = addr_t'(a);
    bus.rd_done = done;
    step();
    bus.exec = 1'b0;
    bus.rd_done = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    checks++; if (bus.full_cnt !== 2'd0) $display("FAIL rst_cnt got %0d exp 0", bus.full_cnt); else passed++;
    checks++; if (bus.d !== 32'd0) $display("FAIL rst_d got %0d exp 0", bus.d); else passed++;
    checks++; if (bus.d_v !== 1'b0) $display("FAIL rst_dv got %b exp 0", bus.d_v); else passed++;
    checks++; if ({bus.err_ovf, bus.err_udf} !== 2'b00) $display("FAIL rst_err got %b exp 00", {bus.err_ovf, bus.err_udf}); else passed++;
    checks++; if ({bus.src_rdy, bus.rd_rdy} !== 2'b10) $display("FAIL rst_rdy got %b exp 10", {bus.src_rdy, bus.rd_rdy}); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fill;
    wr(0, 10, 0);
    wr(1, 11, 0);
    wr(2, 12, 0);
    bus.src_v = 1'b1; bus.src_a = 12'd3; bus.src_d = 32'd13; bus.src_last = 1'b1;
    #1;
    checks++; if (bus.rd_rdy !== 1'b0) $display("FAIL fill_same_cycle_rdy got %b exp 0", bus.rd_rdy); else passed++;
    step();
    bus.src_v = 1'b0; bus.src_last = 1'b0;
    checks++; if (bus.full_cnt !== 2'd1) $display("FAIL fill_cnt got %0d exp 1", bus.full_cnt); else passed++;
    checks++; if ({bus.src_rdy, bus.rd_rdy} !== 2'b11) $display("FAIL fill_rdy got %b exp 11", {bus.src_rdy, bus.rd_rdy}); else passed++;
  endtask

  task automatic test_read;
    rd(2, 0);
    checks++; if (bus.d !== 32'd12) $display("FAIL read_d got %0d exp 12", bus.d); else passed++;
    checks++; if (bus.d_v !== 1'b1) $display("FAIL read_dv got %b exp 1", bus.d_v); else passed++;
    step();
    checks++; if (bus.d !== 32'd12) $display("FAIL idle_d got %0d exp 12", bus.d); else passed++;
    checks++; if (bus.d_v !== 1'b0) $display("FAIL idle_dv got %b exp 0", bus.d_v); else passed++;
    rd(0, 0);
    checks++; if (bus.d !== 32'd10) $display("FAIL read0_d got %0d exp 10", bus.d); else passed++;
  endtask

  task automatic test_full;
    wr(0, 20, 0);
    wr(1, 21, 0);
    wr(2, 22, 0);
    wr(3, 23, 1);
    checks++; if (bus.full_cnt !== 2'd2) $display("FAIL full_cnt got %0d exp 2", bus.full_cnt); else passed++;
    checks++; if (bus.src_rdy !== 1'b0) $display("FAIL full_src_rdy got %b exp 0", bus.src_rdy); else passed++;
    wr(0, 99, 0);
    checks++; if (bus.err_ovf !== 1'b1) $display("FAIL ovf_flag got %b exp 1", bus.err_ovf); else passed++;
    checks++; if (bus.full_cnt !== 2'd2) $display("FAIL ovf_cnt got %0d exp 2", bus.full_cnt); else passed++;
    rd(0, 0);
    checks++; if (bus.d !== 32'd10) $display("FAIL ovf_mem got %0d exp 10", bus.d); else passed++;
    bus.rd_done = 1'b1;
    wr(1, 77, 0);
    bus.rd_done = 1'b0;
    checks++; if (bus.full_cnt !== 2'd1) $display("FAIL release_cnt got %0d exp 1", bus.full_cnt); else passed++;
    checks++; if (bus.src_rdy !== 1'b1) $display("FAIL release_src_rdy got %b exp 1", bus.src_rdy); else passed++;
    checks++; if (bus.err_udf !== 1'b0) $display("FAIL release_udf got %b exp 0", bus.err_udf); else passed++;
  endtask

  task automatic test_back_to_back;
    rd(2, 0);
    checks++; if (bus.d !== 32'd22) $display("FAIL bank1_d got %0d exp 22", bus.d); else passed++;
    wr(0, 30, 0);
    bus.rd_done = 1'b1;
    wr(3, 33, 1);
    bus.rd_done = 1'b0;
    checks++; if (bus.full_cnt !== 2'd1) $display("FAIL b2b_cnt got %0d exp 1", bus.full_cnt); else passed++;
    checks++; if ({bus.src_rdy, bus.rd_rdy} !== 2'b11) $display("FAIL b2b_rdy got %b exp 11", {bus.src_rdy, bus.rd_rdy}); else passed++;
    rd(3, 0);
    checks++; if (bus.d !== 32'd33) $display("FAIL b2b_new_bank got %0d exp 33", bus.d); else passed++;
    rd(1, 0);
    checks++; if (bus.d !== 32'd11) $display("FAIL rejected_write got %0d exp 11", bus.d); else passed++;
    rd(0, 0);
    checks++; if (bus.d !== 32'd30) $display("FAIL b2b_addr0 got %0d exp 30", bus.d); else passed++;
  endtask

  task automatic test_underflow;
    bus.rd_done = 1'b1;
    step();
    bus.rd_done = 1'b0;
    checks++; if ({bus.full_cnt, bus.rd_rdy} !== 3'b000) $display("FAIL empty got %b exp 000", {bus.full_cnt, bus.rd_rdy}); else passed++;
    checks++; if (bus.err_udf !== 1'b0) $display("FAIL early_udf got %b exp 0", bus.err_udf); else passed++;
    rd(0, 0);
    checks++; if (bus.d_v !== 1'b0) $display("FAIL udf_dv got %b exp 0", bus.d_v); else passed++;
    checks++; if (bus.d !== 32'd30) $display("FAIL udf_d got %0d exp 30", bus.d); else passed++;
    checks++; if (bus.err_udf !== 1'b1) $display("FAIL udf_flag got %b exp 1", bus.err_udf); else passed++;
    wr(0, 40, 0);
    wr(1, 41, 1);
    checks++; if (bus.full_cnt !== 2'd1) $display("FAIL refill_cnt got %0d exp 1", bus.full_cnt); else passed++;
    rd(1, 1);
    checks++; if (bus.d !== 32'd41) $display("FAIL exec_done_d got %0d exp 41", bus.d); else passed++;
    checks++; if (bus.d_v !== 1'b1) $display("FAIL exec_done_dv got %b exp 1", bus.d_v); else passed++;
    checks++; if (bus.full_cnt !== 2'd0) $display("FAIL exec_done_cnt got %0d exp 0", bus.full_cnt); else passed++;
  endtask

  task automatic test_async_reset;
    wr(0, 50, 1);
    rd(0, 0);
    checks++; if (bus.d !== 32'd50) $display("FAIL pre_rst_d got %0d exp 50", bus.d); else passed++;
    wr(0, 60, 0);
    checks++; if (bus.full_cnt !== 2'd1) $display("FAIL pre_rst_cnt got %0d exp 1", bus.full_cnt); else passed++;
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.full_cnt !== 2'd0) $display("FAIL arst_cnt got %0d exp 0", bus.full_cnt); else passed++;
    checks++; if (bus.d !== 32'd0) $display("FAIL arst_d got %0d exp 0", bus.d); else passed++;
    checks++; if ({bus.err_ovf, bus.err_udf, bus.d_v} !== 3'b000) $display("FAIL arst_flags got %b exp 000", {bus.err_ovf, bus.err_udf, bus.d_v}); else passed++;
    checks++; if ({bus.src_rdy, bus.rd_rdy} !== 2'b10) $display("FAIL arst_rdy got %b exp 10", {bus.src_rdy, bus.rd_rdy}); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    wr(0, 70, 1);
    rd(0, 0);
    checks++; if (bus.d !== 32'd70) $display("FAIL post_rst_bank0 got %0d exp 70", bus.d); else passed++;
    checks++; if (bus.d_v !== 1'b1) $display("FAIL post_rst_dv got %b exp 1", bus.d_v); else passed++;
  endtask

  initial begin
    bus.src_v = 1'b0;
    bus.src_a = '0;
    bus.src_d = '0;
    bus.src_last = 1'b0;
    bus.exec = 1'b0;
    bus.ia = '0;
    bus.rd_done = 1'b0;
    test_reset();
    test_fill();
    test_read();
    test_full();
    test_back_to_back();
    test_underflow();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
